// File: rtl/scr1_vec_dmem_responder_pkg.sv
// rtl/scr1_vec_dmem_responder_pkg.sv - shared types and helpers for the vector dmem responder
package scr1_vec_dmem_responder_pkg;

    localparam int LANE             = 4;
    localparam int SCR1_DMEM_AWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef logic [LANE-1:0][31:0] type_vector;

    function automatic logic [3:0] scr1_vresp_be(input type_scr1_mem_width_e w, input logic [1:0] off);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << off;
            SCR1_MEM_WIDTH_HWORD: return 4'b0011 << off;
            default:              return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/scr1_vec_dmem_responder_if.sv
// rtl/scr1_vec_dmem_responder_if.sv - dmem req/ack/resp bus with vector data path
interface scr1_vec_dmem_responder_if;
    import scr1_vec_dmem_responder_pkg::*;

    logic                              req;
    logic                              req_ack;
    type_scr1_mem_cmd_e                cmd;
    type_scr1_mem_width_e              width;
    logic [SCR1_DMEM_AWIDTH-1:0]       addr;
    type_vector                        wdata;
    type_vector                        rdata;
    type_scr1_mem_resp_e               resp;

    modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
    modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);

endinterface

// File: rtl/scr1_vec_dmem_responder_bank.sv
// rtl/scr1_vec_dmem_responder_bank.sv - one lane: 32-bit byte-enabled synchronous RAM
module scr1_vec_bank #(
    parameter int ROW_DEPTH = 256,
    parameter int ROW_W     = $clog2(ROW_DEPTH)
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             re_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [ROW_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [3:0][7:0] mem_q [ROW_DEPTH];
    logic [31:0]     rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Output register clears on reset or error, otherwise holds between reads.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scr1_vec_dmem_responder.sv
// rtl/scr1_vec_dmem_responder.sv - dmem target serving LANE x 32-bit rows with wait states
module scr1_vec_dmem_responder
    import scr1_vec_dmem_responder_pkg::*;
#(
    parameter int                          ROW_DEPTH   = 256,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] BASE_ADDR   = 32'h0001_0000,
    parameter int                          WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    scr1_vec_dmem_responder_if.slave dmem
);

    localparam int ROW_W     = $clog2(ROW_DEPTH);
    localparam int ROW_BYTES = LANE * 4;
    localparam int ROW_SHIFT = $clog2(ROW_BYTES);
    localparam logic [SCR1_DMEM_AWIDTH:0] SPAN = (SCR1_DMEM_AWIDTH+1)'(ROW_DEPTH * ROW_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} type_scr1_vresp_fsm_e;

    type_scr1_vresp_fsm_e        state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic                        err_q, err_d;
    type_scr1_mem_cmd_e          cmd_q;
    type_scr1_mem_width_e        width_q;
    logic [SCR1_DMEM_AWIDTH-1:0] addr_q;
    type_vector                  wdata_q;

    logic                        accept;
    logic                        do_access;
    type_scr1_mem_cmd_e          acc_cmd;
    type_scr1_mem_width_e        acc_width;
    logic [SCR1_DMEM_AWIDTH-1:0] acc_addr;
    type_vector                  acc_wdata;
    logic [SCR1_DMEM_AWIDTH-1:0] offset;
    logic [1:0]                  byte_off;
    logic [ROW_W-1:0]            row;
    logic                        acc_err;
    logic [3:0]                  be;
    type_vector                  lane_wdata;
    type_vector                  rdata_v;
    logic                        bank_we, bank_re, bank_clr;

    assign dmem.req_ack = (state_q != WAIT);
    assign accept       = dmem.req & dmem.req_ack;

    // Zero wait states access straight off the bus at the accept edge; otherwise from the captured copy.
    assign do_access = ((state_q == WAIT) && (cnt_q == '0)) || (accept && (WAIT_STATES == 0));
    assign acc_cmd   = (state_q == WAIT) ? cmd_q   : dmem.cmd;
    assign acc_width = (state_q == WAIT) ? width_q : dmem.width;
    assign acc_addr  = (state_q == WAIT) ? addr_q  : dmem.addr;
    assign acc_wdata = (state_q == WAIT) ? wdata_q : dmem.wdata;

    assign offset   = acc_addr - BASE_ADDR;
    assign byte_off = acc_addr[1:0];
    assign row      = ROW_W'(offset >> ROW_SHIFT);
    assign be       = scr1_vresp_be(acc_width, byte_off);

    always_comb begin
        acc_err = 1'b0;
        if ((acc_cmd != SCR1_MEM_CMD_RD) && (acc_cmd != SCR1_MEM_CMD_WR)) acc_err = 1'b1;
        if (acc_width == SCR1_MEM_WIDTH_ERROR)                            acc_err = 1'b1;
        if ({1'b0, offset} >= SPAN)                                       acc_err = 1'b1;
        if ((acc_width == SCR1_MEM_WIDTH_HWORD) && byte_off[0])           acc_err = 1'b1;
        if ((acc_width == SCR1_MEM_WIDTH_WORD) && (byte_off != 2'b00))    acc_err = 1'b1;
    end

    always_comb begin
        lane_wdata = '0;
        for (int l = 0; l < LANE; l++) begin
            lane_wdata[l] = acc_wdata[l] << {byte_off, 3'b000};
        end
    end

    assign bank_we  = do_access & ~acc_err & (acc_cmd == SCR1_MEM_CMD_WR) & ~rst;
    assign bank_re  = do_access & ~acc_err & (acc_cmd == SCR1_MEM_CMD_RD) & ~rst;
    assign bank_clr = rst | (do_access & acc_err);

    for (genvar l = 0; l < LANE; l++) begin : g_lane
        scr1_vec_bank #(
            .ROW_DEPTH (ROW_DEPTH),
            .ROW_W     (ROW_W)
        ) u_bank (
            .clk     (clk),
            .clr_i   (bank_clr),
            .re_i    (bank_re),
            .we_i    (bank_we),
            .be_i    (be),
            .addr_i  (row),
            .wdata_i (lane_wdata[l]),
            .rdata_o (rdata_v[l])
        );
    end

    assign dmem.rdata = rdata_v;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dmem.resp = SCR1_MEM_RESP_NOTRDY;
        case (state_q)
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                if (state_q == RESP) begin
                    dmem.resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                end
                if (!accept) begin
                    state_d = IDLE;
                end else if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = 3'(WAIT_STATES - 1);
                end else begin
                    state_d = RESP;
                    err_d   = acc_err;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q   <= dmem.cmd;
            width_q <= dmem.width;
            addr_q  <= dmem.addr;
            wdata_q <= dmem.wdata;
        end
    end

endmodule
